// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch into a small circular buffer.
// Ports: clk, rst_n (async, active-low); instr_addr/instr = memory port;
//        redirect_valid/redirect_pc = flush and restart;
//        out_valid/out_ready/out_instr/out_pc = head entry to decode;
//        misalign_err = pulse after a redirect with unaligned target.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        misalign_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [31:0]   pc_buf_q    [DEPTH];
    logic [31:0]   instr_buf_q [DEPTH];
    logic          misalign_q;

    logic push;
    logic pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign out_valid = (count_q != '0);
    // Redirect blocks both sides of the buffer for the cycle it is sampled.
    assign pop  = out_valid && out_ready && !redirect_valid;
    assign push = !redirect_valid && ((count_q < CW'(DEPTH)) || pop);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
        end else begin
            if (push) begin
                // Natural 32-bit wrap at the top of the address space.
                fetch_pc_d = fetch_pc_q + 32'd4;
                tail_d     = ptr_inc(tail_q);
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            misalign_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            misalign_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_buf_q[i]    <= '0;
                instr_buf_q[i] <= '0;
            end
        end else if (push) begin
            pc_buf_q[tail_q]    <= fetch_pc_q;
            instr_buf_q[tail_q] <= instr;
        end
    end

    assign instr_addr   = fetch_pc_q;
    assign out_pc       = pc_buf_q[head_q];
    assign out_instr    = instr_buf_q[head_q];
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a queue-based scoreboard.
// The monitor pops expected {pc, instr} pairs on every decode handshake.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] instr_addr;
    logic [31:0] instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        misalign_err;

    int nvec = 0;
    int nmis = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t sb[$];

    fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_addr     (instr_addr),
        .instr          (instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        if (a == 32'h4) return 32'h0050_0093;
        return a ^ 32'h1357_9BDF;
    endfunction

    always_comb instr = mem(instr_addr);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        sb.push_back({pc, mem(pc)});
    endtask

    // Monitor: the handshake seen at a negedge is what the next edge consumes.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready && !redirect_valid) begin
                nvec++;
                if (sb.size() == 0) begin
                    nmis++;
                    $display("FAIL accept_unexpected: got pc %h none expected",
                             out_pc);
                end else begin
                    e = sb.pop_front();
                    if (out_pc !== e.pc || out_instr !== e.ins) begin
                        nmis++;
                        $display("FAIL accept: got %h/%h expected %h/%h",
                                 out_pc, out_instr, e.pc, e.ins);
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_instr_addr", instr_addr, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_misalign", 32'(misalign_err), 32'h0);

        // Streaming after reset release
        step();
        expect_pc(32'h0);
        expect_pc(32'h4);
        expect_pc(32'h8);
        out_ready = 1'b1;
        rst_n = 1'b1;
        step();
        chk("first_push_valid", 32'(out_valid), 32'h1);
        step();
        step();
        step();
        out_ready = 1'b0;
        step();
        step();
        step();

        // Asynchronous reset between edges with a full buffer
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'h0);
        chk("async_rst_addr", instr_addr, 32'h0);
        #1 rst_n = 1'b1;

        // Stall: buffer fills to 2 and fetch_pc parks at 0x8
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_pc_stable", out_pc, 32'h0);
        end
        chk("stall_addr", instr_addr, 32'h8);
        chk("stall_valid", 32'(out_valid), 32'h1);
        expect_pc(32'h0);
        expect_pc(32'h4);
        expect_pc(32'h8);
        out_ready = 1'b1;
        step();
        step();
        step();
        out_ready = 1'b0;
        step();
        step();

        // Redirect on a full buffer while decode is ready
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        out_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        chk("redir_flush_valid", 32'(out_valid), 32'h0);
        chk("redir_addr", instr_addr, 32'h40);
        chk("redir_misalign0", 32'(misalign_err), 32'h0);
        step();
        chk("redir_lat_valid", 32'(out_valid), 32'h1);
        chk("redir_lat_pc", out_pc, 32'h40);
        chk("redir_lat_instr", out_instr, mem(32'h40));

        // Unaligned redirect target
        redirect_valid = 1'b1;
        redirect_pc = 32'h42;
        step();
        redirect_valid = 1'b0;
        chk("mis_addr", instr_addr, 32'h40);
        chk("mis_pulse", 32'(misalign_err), 32'h1);
        step();
        chk("mis_clear", 32'(misalign_err), 32'h0);
        chk("mis_pc", out_pc, 32'h40);

        // Back-to-back redirects: the last one wins
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect_pc = 32'h200;
        step();
        redirect_valid = 1'b0;
        chk("b2b_addr", instr_addr, 32'h200);
        step();
        chk("b2b_pc", out_pc, 32'h200);

        // Wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        expect_pc(32'hFFFF_FFFC);
        expect_pc(32'h0);
        out_ready = 1'b1;
        step();
        step();
        step();
        out_ready = 1'b0;
        chk("wrap_misalign", 32'(misalign_err), 32'h0);

        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            step();
            guard++;
        end
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
